cmpl_arbiter: RTL and testbench

//  Shares one combinational 8-bit 2's complement (negate) unit between NUM_REQ

---
 rtl/cmpl_arbiter.sv | 134 +++++++++++++
 tb/tb_cmpl_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/cmpl_arbiter.sv
// Round-robin arbiter sharing one combinational negate unit between requesters.
// Operand is latched on accept, result captured one cycle later and held until taken.
module cmpl_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 2,
  parameter int IDW     = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]         cmpl_data,
  input  logic [WIDTH-1:0]         cmpl_result,
  output logic                     rsp_valid,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [IDW-1:0]           rsp_id,
  output logic                     rsp_ovf,
  input  logic                     rsp_ready
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [WIDTH-1:0] MIN_NEG =
    {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [IDW:0] NREQ = (IDW+1)'(NUM_REQ);

  logic [1:0]       state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic             rsp_ovf_q, rsp_ovf_d;

  logic               any_req;
  logic [IDW-1:0]     gnt_id;
  logic [NUM_REQ-1:0] gnt_vec;
  logic [WIDTH-1:0]   gnt_data;
  logic [IDW:0]       scan;
  logic [IDW:0]       nxt_ptr;

  // Search upward from rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    any_req = 1'b0;
    gnt_id  = '0;
    scan    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (scan >= NREQ) scan = scan - NREQ;
      if (!any_req && req_valid[scan[IDW-1:0]]) begin
        any_req = 1'b1;
        gnt_id  = scan[IDW-1:0];
      end
    end
    gnt_vec  = any_req ? (NUM_REQ'(1) << gnt_id) : '0;
    gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_vec[i]) gnt_data = req_data[i*WIDTH +: WIDTH];
    end
    nxt_ptr = {1'b0, gnt_id} + (IDW+1)'(1);
    if (nxt_ptr >= NREQ) nxt_ptr = '0;
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    op_d        = op_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_ovf_d   = rsp_ovf_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (any_req) begin
          op_d     = gnt_data;
          id_d     = gnt_id;
          rr_ptr_d = nxt_ptr[IDW-1:0];
          state_d  = S_ISSUE;
        end
      end
      (state_q == S_ISSUE): begin
        rsp_data_d  = cmpl_result;
        rsp_id_d    = id_q;
        rsp_ovf_d   = (op_q == MIN_NEG);
        rsp_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      (state_q == S_HOLD): begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      op_q        <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      op_q        <= op_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_ovf_q   <= rsp_ovf_d;
    end
  end

  // Gated by resetn so no strobe escapes while reset is asserted.
  assign req_ready =
    (state_q == S_IDLE && resetn) ? gnt_vec : '0;
  assign cmpl_data = op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_cmpl_arbiter.sv
// Directed and randomized checks of cmpl_arbiter.
// The bench supplies the external negate unit.
module tb_cmpl_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic [7:0]  cmpl_data;
  logic [7:0]  cmpl_result;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic        rsp_ovf;
  logic        rsp_ready;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign cmpl_result = ~cmpl_data + 8'd1;

  cmpl_arbiter #(.WIDTH(8), .NUM_REQ(2), .IDW(2)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready),
    .cmpl_data(cmpl_data), .cmpl_result(cmpl_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_ovf(rsp_ovf),
    .rsp_ready(rsp_ready)
  );

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Entered at the negedge after the accept edge.
  task automatic serve(input logic [1:0] eid,
                       input logic [7:0] edat,
                       input logic eovf,
                       input int dly);
    int n;
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_valid_seen", 16'(rsp_valid), 16'd1);
    repeat (dly) begin
      chk("hold_data", 16'(rsp_data), 16'(edat));
      chk("hold_rdy", 16'(req_ready), 16'd0);
      @(negedge clk);
    end
    chk("rsp_valid", 16'(rsp_valid), 16'd1);
    chk("rsp_data", 16'(rsp_data), 16'(edat));
    chk("rsp_id", 16'(rsp_id), 16'(eid));
    chk("rsp_ovf", 16'(rsp_ovf), 16'(eovf));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_drop", 16'(rsp_valid), 16'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] mask;
    logic [7:0] d0, d1, dg;
    int g, mrr, dly;

    resetn = 1'b0;
    req_valid = '0;
    req_data = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 16'(rsp_valid), 16'd0);
    chk("rst_data", 16'(rsp_data), 16'd0);
    chk("rst_cmpl", 16'(cmpl_data), 16'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("idle_rdy", 16'(req_ready), 16'd0);

    // 1: single request from requester 0
    req_valid = 2'b01;
    req_data = 16'h0003;
    #1 chk("t1_rdy", 16'(req_ready), 16'h1);
    @(negedge clk);
    req_valid = '0;
    chk("t1_rdy_off", 16'(req_ready), 16'd0);
    chk("t1_cmpl", 16'(cmpl_data), 16'h03);
    chk("t1_lat", 16'(rsp_valid), 16'd0);
    serve(2'd0, 8'hFD, 1'b0, 0);

    // 2: zero and most-negative operand on requester 1
    req_valid = 2'b10;
    req_data = 16'h0000;
    #1 chk("t2a_rdy", 16'(req_ready), 16'h2);
    @(negedge clk);
    req_valid = '0;
    serve(2'd1, 8'h00, 1'b0, 0);
    req_valid = 2'b10;
    req_data = 16'h8000;
    #1 chk("t2b_rdy", 16'(req_ready), 16'h2);
    @(negedge clk);
    req_valid = '0;
    serve(2'd1, 8'h80, 1'b1, 0);

    // 3: both held valid, alternating service
    req_valid = 2'b11;
    req_data = 16'h0201;
    #1 chk("t3_rdy0", 16'(req_ready), 16'h1);
    @(negedge clk);
    chk("t3_busy", 16'(req_ready), 16'd0);
    serve(2'd0, 8'hFF, 1'b0, 0);
    chk("t3_rdy1", 16'(req_ready), 16'h2);
    @(negedge clk);
    serve(2'd1, 8'hFE, 1'b0, 0);
    chk("t3_rdy2", 16'(req_ready), 16'h1);
    @(negedge clk);
    serve(2'd0, 8'hFF, 1'b0, 0);
    req_valid = '0;

    // 4: consumer stalls while requester 0 waits
    req_valid = 2'b10;
    req_data = 16'h1000;
    @(negedge clk);
    req_valid = 2'b01;
    req_data = 16'h0020;
    @(negedge clk);
    serve(2'd1, 8'hF0, 1'b0, 5);
    chk("t4_rdy", 16'(req_ready), 16'h1);
    @(negedge clk);
    req_valid = '0;
    serve(2'd0, 8'hE0, 1'b0, 0);

    // 5: reset during ISSUE
    req_valid = 2'b10;
    req_data = 16'h5500;
    @(negedge clk);
    chk("t5_cmpl", 16'(cmpl_data), 16'h55);
    req_valid = 2'b11;
    req_data = 16'h557F;
    resetn = 1'b0;
    #1;
    chk("t5_cmpl0", 16'(cmpl_data), 16'd0);
    chk("t5_rdy0", 16'(req_ready), 16'd0);
    chk("t5_vld0", 16'(rsp_valid), 16'd0);
    chk("t5_id0", 16'(rsp_id), 16'd0);
    @(negedge clk);
    resetn = 1'b1;
    #1 chk("t5_rr0", 16'(req_ready), 16'h1);
    @(negedge clk);
    req_valid = '0;
    serve(2'd0, 8'h81, 1'b0, 0);

    // 6: random traffic against a round-robin model
    mrr = 1;
    for (int op = 0; op < 300; op++) begin
      mask = 2'($urandom_range(1, 3));
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      if (op % 50 == 0) d0 = 8'h80;
      req_valid = mask;
      req_data = {d1, d0};
      g = mask[mrr] ? mrr : 1 - mrr;
      dg = (g == 0) ? d0 : d1;
      #1 chk("r_rdy", 16'(req_ready), 16'(2'b01 << g));
      mrr = 1 - g;
      @(negedge clk);
      req_valid = '0;
      dly = $urandom_range(0, 3);
      serve(2'(g), 8'(8'h00 - dg), dg == 8'h80, dly);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
